// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the hazard/memory side and the pipeline stall controller.
// The master drives the hazard sources and the slave returns the per-stage controls.
interface pipeline_stall_controller_if #(
  parameter int unsigned CNT_W = 32
);
  logic             hazard_detected;
  logic             branch_taken;
  logic             mem_wait;
  logic             pc_write_en;
  logic             ifid_write_en;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             pipe_freeze;
  logic             timeout_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output hazard_detected, branch_taken, mem_wait,
    input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble, pipe_freeze,
    input  timeout_err, stall_cnt, flush_cnt
  );

  modport slave (
    input  hazard_detected, branch_taken, mem_wait,
    output pc_write_en, ifid_write_en, ifid_flush, idex_bubble, pipe_freeze,
    output timeout_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Turns load-use hazards, taken branches and data-memory waits into per-stage pipeline
// controls, with multi-cycle branch flush, a memory-wait watchdog and saturating counters.
module pipeline_stall_controller #(
  parameter int unsigned FLUSH_CYCLES   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipeline_stall_controller_if.slave   ctrl
);

  localparam int unsigned WaitW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StRun, StFlush, StError} state_e;

  state_e           state_q, state_d;
  logic [3:0]       flush_left_q, flush_left_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             err_q, err_d;

  logic pc_we, ifid_we, ifid_fl, idex_bub, freeze;

  // Control outputs act in the same cycle; priority ERROR > mem_wait > branch > hazard.
  always_comb begin
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    ifid_fl  = 1'b0;
    idex_bub = 1'b0;
    freeze   = 1'b0;
    if (!rst_n) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      ifid_fl  = 1'b1;
      idex_bub = 1'b1;
    end else if (state_q == StError || ctrl.mem_wait) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      freeze  = 1'b1;
    end else if (state_q == StFlush || ctrl.branch_taken) begin
      ifid_fl  = 1'b1;
      idex_bub = 1'b1;
    end else if (ctrl.hazard_detected) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      idex_bub = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;

    if (!pc_we && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ifid_fl && flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);

    case (state_q)
      StError: ;
      default: begin
        if (ctrl.mem_wait) begin
          // The TIMEOUT_CYCLES-th consecutive wait cycle trips the watchdog.
          if (wait_cnt_q == WaitW'(TIMEOUT_CYCLES - 1)) begin
            state_d = StError;
            err_d   = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WaitW'(1);
          end
        end else begin
          wait_cnt_d = '0;
          if (ctrl.branch_taken) begin
            if (FLUSH_CYCLES > 1) begin
              state_d      = StFlush;
              flush_left_d = 4'(FLUSH_CYCLES - 1);
            end
          end else if (state_q == StFlush) begin
            flush_left_d = flush_left_q - 4'd1;
            if (flush_left_q == 4'd1) state_d = StRun;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StRun;
      flush_left_q <= '0;
      wait_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_left_q <= flush_left_d;
      wait_cnt_q   <= wait_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      err_q        <= err_d;
    end
  end

  assign ctrl.pc_write_en   = pc_we;
  assign ctrl.ifid_write_en = ifid_we;
  assign ctrl.ifid_flush    = ifid_fl;
  assign ctrl.idex_bubble   = idex_bub;
  assign ctrl.pipe_freeze   = freeze;
  assign ctrl.timeout_err   = err_q;
  assign ctrl.stall_cnt     = stall_cnt_q;
  assign ctrl.flush_cnt     = flush_cnt_q;

endmodule
